multi_channel_packet_counter: RTL and testbench
===============================================

MULTI_CHANNEL_PACKET_COUNTER -- requirements
Module: multi_channel_packet_counter

Interface
REQ-001 Parameter N_CH, default 4: number of counted channels, 1..256.
REQ-002 Parameter CNT_W, default 16: per-channel packet-counter width, 4..32.
REQ-003 Parameter INTV_W, default 16: interval-number width.
REQ-004 Parameter CH_W, default 8: channel-number width; N_CH <= 2^CH_W.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 clr  in  1  reset, synchronous, active-high.
REQ-007 ev  in  1  packet event, one-cycle qualifier.
REQ-008 n_ch  in  CH_W  channel number of the event, sampled with ev.
REQ-009 numb_inter  in  INTV_W  current interval number after the second mark, sampled with ev.
REQ-010 new_int  in  1  interval-start strobe; clears all channel counters.
REQ-011 q  out  INTV_W+CNT_W  tag {numb_inter, packet index within interval}.
REQ-012 q_ch  out  CH_W  channel of the tag in q.
REQ-013 q_valid  out  1  q/q_ch hold a tag not yet accepted.
REQ-014 q_ready  in  1  downstream accepts q when q_valid && q_ready.
REQ-015 wrap  out  N_CH  sticky per-channel counter-wrap flags.
REQ-016 err_ch  out  1  one-cycle pulse: ev with n_ch >= N_CH.
REQ-017 lost_cnt  out  8  saturating count of tags dropped by backpressure.

Function
REQ-018 The block SHALL hold one CNT_W counter per channel, cnt[0..N_CH-1].
REQ-019 On ev with n_ch < N_CH, the tag index SHALL be the pre-increment value cnt[n_ch], and cnt[n_ch] SHALL become cnt[n_ch]+1 modulo 2^CNT_W.
REQ-020 The tag SHALL appear on q as {numb_inter, index} with q_ch = n_ch and q_valid = 1 on the cycle after ev; latency is 1 clk.
REQ-021 On a counter step from 2^CNT_W-1 to 0, wrap[n_ch] SHALL set and remain set until new_int or clr.
REQ-022 On ev with n_ch >= N_CH, no counter, q, q_ch or q_valid SHALL change; err_ch SHALL be 1 for exactly the next cycle.
REQ-023 q, q_ch and q_valid SHALL hold stable while q_valid && !q_ready.
REQ-024 When q_valid && q_ready with no valid ev, q_valid SHALL fall to 0 on the next cycle.
REQ-025 When q_valid && q_ready coincide with a valid ev, the new tag SHALL load and q_valid SHALL stay 1.
REQ-026 On a valid ev while q_valid && !q_ready, the counter SHALL still advance; q SHALL keep the old tag, and lost_cnt SHALL increment, saturating at 255.
REQ-027 On new_int, all cnt SHALL clear to 0 and all wrap bits SHALL clear on the next cycle.
REQ-028 When new_int and a valid ev coincide, the event SHALL belong to the new interval: index 0, cnt[n_ch] = 1 afterwards, and the other counters = 0.
REQ-029 Events on different channels SHALL never affect each other's counters.
REQ-030 lost_cnt and err_ch SHALL be unaffected by new_int.

Reset
REQ-031 When clr = 1 at a clock edge, all cnt, q, q_ch, wrap and lost_cnt SHALL become 0, and q_valid and err_ch SHALL become 0.
REQ-032 clr SHALL take priority over ev, new_int and q_ready in the same cycle.
REQ-033 clr mid-handshake SHALL discard the pending tag without acceptance.

Verification
REQ-034 Three ev on ch0, then two on ch1, with numb_inter = 0x0005 and q_ready = 1 -> q = 0x00050000, 0x00050001, 0x00050002, 0x00050000, 0x00050001; q_ch = 0,0,0,1,1.
REQ-035 Preload ch2 to 0xFFFF via 65535 events, then one more ev -> q index = 0xFFFF, cnt[2] = 0, wrap = 4'b0100; then new_int -> wrap = 0.
REQ-036 q_ready = 0, then two ev on ch3 -> q holds index 0, lost_cnt = 1, cnt[3] = 2; raise q_ready -> q_valid drops the next cycle.
REQ-037 new_int and ev(ch1) in the same cycle after 7 prior ch1 events -> tag index 0, cnt[1] = 1.
REQ-038 ev with n_ch = 9 (N_CH = 4) -> err_ch pulses for 1 cycle, q_valid and counters unchanged.
REQ-039 clr asserted with ev, new_int and a pending tag -> all outputs 0 the next cycle; the next ev(ch0) -> index 0.

Source files
------------

// File: rtl/multi_channel_packet_counter.sv
// multi_channel_packet_counter
// Per-channel packet indexer. Each valid event on channel n receives the
// current value of that channel's counter as its index within the current
// interval. The tag {interval number, index} is presented on a one-entry
// valid/ready output register. A new interval clears every counter and
// wrap flag. Tags that arrive while the output is stalled are counted as lost.
module multi_channel_packet_counter #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int INTV_W = 16,
  parameter int CH_W   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_clr,
  input  logic                    i_ev,
  input  logic [CH_W-1:0]         i_n_ch,
  input  logic [INTV_W-1:0]       i_numb_inter,
  input  logic                    i_new_int,
  output logic [INTV_W+CNT_W-1:0] o_q,
  output logic [CH_W-1:0]         o_q_ch,
  output logic                    o_q_valid,
  input  logic                    i_q_ready,
  output logic [N_CH-1:0]         o_wrap,
  output logic                    o_err_ch,
  output logic [7:0]              o_lost_cnt
);

  // The range check uses one extra bit so that N_CH = 2^CH_W is representable.
  localparam logic [CH_W:0] LP_N_CH = (CH_W+1)'(N_CH);

  logic [CNT_W-1:0]        r_cnt [N_CH];
  logic [N_CH-1:0]         r_wrap;
  logic [INTV_W+CNT_W-1:0] r_q;
  logic [CH_W-1:0]         r_q_ch;
  logic                    r_q_valid;
  logic                    r_err_ch;
  logic [7:0]              r_lost_cnt;

  logic                    w_ch_ok;
  logic                    w_ev_ok;
  logic                    w_ev_bad;
  logic [N_CH-1:0]         w_hit;
  logic [CNT_W-1:0]        w_cur;
  logic [CNT_W-1:0]        w_idx;
  logic                    w_wrap_step;
  logic                    w_load;
  logic                    w_drop;

  assign w_ch_ok  = ({1'b0, i_n_ch} < LP_N_CH);
  assign w_ev_ok  = i_ev & w_ch_ok;
  assign w_ev_bad = i_ev & ~w_ch_ok;

  // Decode the event channel to a one-hot hit vector and select its counter.
  always_comb begin
    w_hit = '0;
    w_cur = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (i_n_ch == CH_W'(c)) begin
        w_hit[c] = w_ev_ok;
        w_cur    = r_cnt[c];
      end
    end
  end

  // An event coinciding with new_int belongs to the new interval, so its
  // index is 0 and it can never be the step that wraps the old counter.
  assign w_idx       = i_new_int ? '0 : w_cur;
  assign w_wrap_step = w_ev_ok & ~i_new_int & (w_cur == '1);

  // The output register takes a new tag when it is empty or being drained;
  // otherwise the tag is dropped and only counted.
  assign w_load = w_ev_ok & (~r_q_valid | i_q_ready);
  assign w_drop = w_ev_ok & r_q_valid & ~i_q_ready;

  // Per-channel counters: cleared by clr, reset to 0/1 on new_int, else step on hit.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int c = 0; c < N_CH; c++) r_cnt[c] <= '0;
    end else if (i_new_int) begin
      for (int c = 0; c < N_CH; c++) r_cnt[c] <= w_hit[c] ? CNT_W'(1) : '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_hit[c]) r_cnt[c] <= r_cnt[c] + CNT_W'(1);
      end
    end
  end

  // Sticky wrap flags, held until the next interval or clr.
  always_ff @(posedge i_clk) begin
    if (i_clr || i_new_int) begin
      r_wrap <= '0;
    end else if (w_wrap_step) begin
      r_wrap <= r_wrap | w_hit;
    end
  end

  // One-entry tag register with valid/ready handshake; held while stalled.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q       <= '0;
      r_q_ch    <= '0;
      r_q_valid <= 1'b0;
    end else if (w_load) begin
      r_q       <= {i_numb_inter, w_idx};
      r_q_ch    <= i_n_ch;
      r_q_valid <= 1'b1;
    end else if (r_q_valid && i_q_ready) begin
      r_q_valid <= 1'b0;
    end
  end

  // Saturating count of tags lost to backpressure; new_int leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_lost_cnt <= '0;
    end else if (w_drop && (r_lost_cnt != 8'hFF)) begin
      r_lost_cnt <= r_lost_cnt + 8'd1;
    end
  end

  // One-cycle pulse after an event addressed to a channel that does not exist.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_err_ch <= 1'b0;
    end else begin
      r_err_ch <= w_ev_bad;
    end
  end

  assign o_q        = r_q;
  assign o_q_ch     = r_q_ch;
  assign o_q_valid  = r_q_valid;
  assign o_wrap     = r_wrap;
  assign o_err_ch   = r_err_ch;
  assign o_lost_cnt = r_lost_cnt;

endmodule

// File: tb/tb_multi_channel_packet_counter.sv
// Testbench for multi_channel_packet_counter with default parameters.
// A table of single-cycle vectors is applied first, followed by hand-written
// multi-cycle sequences for backpressure, interval restart, wrap and clr.
module tb_multi_channel_packet_counter;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 16;
  localparam int INTV_W = 16;
  localparam int CH_W   = 8;

  typedef struct {
    string       name;
    logic        ev;
    logic [7:0]  nCh;
    logic [15:0] numbInter;
    logic        newInt;
    logic        qReady;
    logic        chkQ;
    logic [31:0] expQ;
    logic [7:0]  expQCh;
    logic        expValid;
    logic        expErr;
    logic [7:0]  expLost;
    logic [3:0]  expWrap;
  } vector_t;

  logic                    clk;
  logic                    clr;
  logic                    ev;
  logic [CH_W-1:0]         nCh;
  logic [INTV_W-1:0]       numbInter;
  logic                    newInt;
  logic [INTV_W+CNT_W-1:0] q;
  logic [CH_W-1:0]         qCh;
  logic                    qValid;
  logic                    qReady;
  logic [N_CH-1:0]         wrap;
  logic                    errCh;
  logic [7:0]              lostCnt;

  int nApplied;
  int nMiscompare;

  vector_t vecs [16];

  multi_channel_packet_counter #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W),
    .INTV_W(INTV_W),
    .CH_W  (CH_W)
  ) dut (
    .i_clk       (clk),
    .i_clr       (clr),
    .i_ev        (ev),
    .i_n_ch      (nCh),
    .i_numb_inter(numbInter),
    .i_new_int   (newInt),
    .o_q         (q),
    .o_q_ch      (qCh),
    .o_q_valid   (qValid),
    .i_q_ready   (qReady),
    .o_wrap      (wrap),
    .o_err_ch    (errCh),
    .o_lost_cnt  (lostCnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vector_t mkVec(string name, logic e, logic [7:0] ch, logic [15:0] ni,
                                    logic ni2, logic rdy, logic chkQ, logic [31:0] eq,
                                    logic [7:0] eqc, logic ev2, logic eerr, logic [7:0] elost,
                                    logic [3:0] ewrap);
    vector_t v;
    v.name = name; v.ev = e; v.nCh = ch; v.numbInter = ni; v.newInt = ni2; v.qReady = rdy;
    v.chkQ = chkQ; v.expQ = eq; v.expQCh = eqc; v.expValid = ev2; v.expErr = eerr;
    v.expLost = elost; v.expWrap = ewrap;
    return v;
  endfunction

  // Drive one cycle of inputs, wait for the edge, then settle before sampling.
  task automatic applyStimulus(input logic e, input logic [7:0] ch, input logic [15:0] ni,
                               input logic ni2, input logic rdy, input logic c);
    ev = e; nCh = ch; numbInter = ni; newInt = ni2; qReady = rdy; clr = c;
    @(posedge clk);
    #1;
    ev = 1'b0; newInt = 1'b0; clr = 1'b0;
  endtask

  task automatic cmpField(input string name, input string field,
                          input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompare++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic chkQ, input logic [31:0] expQ,
                             input logic [7:0] expQCh, input logic expValid, input logic expErr,
                             input logic [7:0] expLost, input logic [3:0] expWrap);
    if (chkQ) begin
      cmpField(name, "q", q, expQ);
      cmpField(name, "q_ch", 32'(qCh), 32'(expQCh));
    end
    cmpField(name, "q_valid", 32'(qValid), 32'(expValid));
    cmpField(name, "err_ch", 32'(errCh), 32'(expErr));
    cmpField(name, "lost_cnt", 32'(lostCnt), 32'(expLost));
    cmpField(name, "wrap", 32'(wrap), 32'(expWrap));
  endtask

  initial begin
    nApplied = 0;
    nMiscompare = 0;
    ev = 1'b0; nCh = '0; numbInter = '0; newInt = 1'b0; qReady = 1'b1; clr = 1'b1;

    //                name     ev ch     ni       nw rdy chkQ expQ          qch   v  err lost wrap
    vecs[0]  = mkVec("seq0a",  1, 8'd0, 16'h0005, 0, 1, 1, 32'h0005_0000, 8'd0, 1, 0, 8'd0, 4'h0);
    vecs[1]  = mkVec("seq0b",  1, 8'd0, 16'h0005, 0, 1, 1, 32'h0005_0001, 8'd0, 1, 0, 8'd0, 4'h0);
    vecs[2]  = mkVec("seq0c",  1, 8'd0, 16'h0005, 0, 1, 1, 32'h0005_0002, 8'd0, 1, 0, 8'd0, 4'h0);
    vecs[3]  = mkVec("seq1a",  1, 8'd1, 16'h0005, 0, 1, 1, 32'h0005_0000, 8'd1, 1, 0, 8'd0, 4'h0);
    vecs[4]  = mkVec("seq1b",  1, 8'd1, 16'h0005, 0, 1, 1, 32'h0005_0001, 8'd1, 1, 0, 8'd0, 4'h0);
    vecs[5]  = mkVec("drain",  0, 8'd0, 16'h0005, 0, 1, 0, 32'h0,         8'd0, 0, 0, 8'd0, 4'h0);
    vecs[6]  = mkVec("badch",  1, 8'd9, 16'h0005, 0, 1, 0, 32'h0,         8'd0, 0, 1, 8'd0, 4'h0);
    vecs[7]  = mkVec("errend", 0, 8'd0, 16'h0005, 0, 1, 0, 32'h0,         8'd0, 0, 0, 8'd0, 4'h0);
    vecs[8]  = mkVec("ch0nxt", 1, 8'd0, 16'h00A3, 0, 1, 1, 32'h00A3_0003, 8'd0, 1, 0, 8'd0, 4'h0);
    vecs[9]  = mkVec("stallA", 1, 8'd1, 16'h00A3, 0, 0, 1, 32'h00A3_0003, 8'd0, 1, 0, 8'd1, 4'h0);
    vecs[10] = mkVec("stallB", 0, 8'd0, 16'h00A3, 0, 0, 1, 32'h00A3_0003, 8'd0, 1, 0, 8'd1, 4'h0);
    vecs[11] = mkVec("badStl", 1, 8'd9, 16'h00A3, 0, 0, 1, 32'h00A3_0003, 8'd0, 1, 1, 8'd1, 4'h0);
    vecs[12] = mkVec("accept", 0, 8'd0, 16'h00A3, 0, 1, 0, 32'h0,         8'd0, 0, 0, 8'd1, 4'h0);
    vecs[13] = mkVec("ch1adv", 1, 8'd1, 16'h00A3, 0, 1, 1, 32'h00A3_0003, 8'd1, 1, 0, 8'd1, 4'h0);
    vecs[14] = mkVec("accNew", 1, 8'd0, 16'h00A3, 0, 1, 1, 32'h00A3_0004, 8'd0, 1, 0, 8'd1, 4'h0);
    vecs[15] = mkVec("idle",   0, 8'd0, 16'h00A3, 0, 1, 0, 32'h0,         8'd0, 0, 0, 8'd1, 4'h0);

    // Reset state.
    applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("reset", 1'b1, 32'h0, 8'd0, 1'b0, 1'b0, 8'd0, 4'h0);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].ev, vecs[i].nCh, vecs[i].numbInter, vecs[i].newInt, vecs[i].qReady, 1'b0);
      checkOutput(vecs[i].name, vecs[i].chkQ, vecs[i].expQ, vecs[i].expQCh, vecs[i].expValid,
                  vecs[i].expErr, vecs[i].expLost, vecs[i].expWrap);
    end

    // Backpressure on ch3: second tag lost, counter still advances.
    applyStimulus(1'b1, 8'd3, 16'h0005, 1'b0, 1'b0, 1'b0);
    checkOutput("bp1", 1'b1, 32'h0005_0000, 8'd3, 1'b1, 1'b0, 8'd1, 4'h0);
    applyStimulus(1'b1, 8'd3, 16'h0005, 1'b0, 1'b0, 1'b0);
    checkOutput("bp2", 1'b1, 32'h0005_0000, 8'd3, 1'b1, 1'b0, 8'd2, 4'h0);
    applyStimulus(1'b0, 8'd0, 16'h0005, 1'b0, 1'b0, 1'b0);
    checkOutput("bpHold", 1'b1, 32'h0005_0000, 8'd3, 1'b1, 1'b0, 8'd2, 4'h0);
    applyStimulus(1'b0, 8'd0, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("bpDrop", 1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 8'd2, 4'h0);
    applyStimulus(1'b1, 8'd3, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("bpCnt", 1'b1, 32'h0005_0002, 8'd3, 1'b1, 1'b0, 8'd2, 4'h0);

    // new_int coinciding with an event after seven prior ch1 events.
    applyStimulus(1'b0, 8'd0, 16'h0005, 1'b1, 1'b1, 1'b0);
    checkOutput("newInt", 1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 8'd2, 4'h0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'd1, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("ch1x7", 1'b1, 32'h0005_0006, 8'd1, 1'b1, 1'b0, 8'd2, 4'h0);
    applyStimulus(1'b1, 8'd1, 16'h0005, 1'b1, 1'b1, 1'b0);
    checkOutput("niEv", 1'b1, 32'h0005_0000, 8'd1, 1'b1, 1'b0, 8'd2, 4'h0);
    applyStimulus(1'b1, 8'd1, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("niEvNxt", 1'b1, 32'h0005_0001, 8'd1, 1'b1, 1'b0, 8'd2, 4'h0);
    applyStimulus(1'b1, 8'd0, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("niOther", 1'b1, 32'h0005_0000, 8'd0, 1'b1, 1'b0, 8'd2, 4'h0);

    // Wrap on ch2 after a full count, then new_int clears it.
    applyStimulus(1'b0, 8'd0, 16'h0005, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 65535; i++) applyStimulus(1'b1, 8'd2, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("preload", 1'b1, 32'h0005_FFFE, 8'd2, 1'b1, 1'b0, 8'd2, 4'h0);
    applyStimulus(1'b1, 8'd2, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("wrapStep", 1'b1, 32'h0005_FFFF, 8'd2, 1'b1, 1'b0, 8'd2, 4'b0100);
    applyStimulus(1'b1, 8'd2, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("wrapZero", 1'b1, 32'h0005_0000, 8'd2, 1'b1, 1'b0, 8'd2, 4'b0100);
    applyStimulus(1'b1, 8'd9, 16'h0005, 1'b1, 1'b1, 1'b0);
    checkOutput("wrapClr", 1'b0, 32'h0, 8'd0, 1'b0, 1'b1, 8'd2, 4'h0);

    // Lost counter saturates at 255 under sustained backpressure.
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'd0, 16'h0005, 1'b0, 1'b0, 1'b0);
    checkOutput("lostSat", 1'b1, 32'h0005_0000, 8'd0, 1'b1, 1'b0, 8'd255, 4'h0);

    // clr with a pending tag, event, new_int and ready all at once.
    applyStimulus(1'b1, 8'd1, 16'h0005, 1'b1, 1'b1, 1'b1);
    checkOutput("clrAll", 1'b1, 32'h0, 8'd0, 1'b0, 1'b0, 8'd0, 4'h0);
    applyStimulus(1'b1, 8'd0, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("clrCh0", 1'b1, 32'h0005_0000, 8'd0, 1'b1, 1'b0, 8'd0, 4'h0);
    applyStimulus(1'b1, 8'd1, 16'h0005, 1'b0, 1'b1, 1'b0);
    checkOutput("clrCh1", 1'b1, 32'h0005_0000, 8'd1, 1'b1, 1'b0, 8'd0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule
